// File: rtl/adder_share_arb.sv
// adder_share_arb: one WIDTH-bit adder time-shared by NREQ round-robin requesters.
// Define ADDER_ARB_OVF_EN to add the registered signed-overflow output ovf_o.

module adder_share_arb_add #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum
);
    assign sum = a + b;
endmodule

module adder_share_arb #(
    parameter int WIDTH = 32,
    parameter int NREQ  = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NREQ-1:0]           req_valid_i,
    output logic [NREQ-1:0]           req_ready_o,
    input  logic [NREQ*WIDTH-1:0]     src1_i,
    input  logic [NREQ*WIDTH-1:0]     src2_i,
    output logic                      res_valid_o,
    input  logic                      res_ready_i,
    output logic [WIDTH-1:0]          res_sum_o,
    output logic [$clog2(NREQ)-1:0]   res_id_o,
`ifdef ADDER_ARB_OVF_EN
    output logic                      ovf_o,
`endif
    output logic                      busy_o
);
    localparam int IDW = $clog2(NREQ);
    localparam logic [IDW:0] NREQ_W = (IDW+1)'(NREQ);

    typedef enum logic [1:0] {IDLE, CALC, HOLD} state_t;

    state_t                     state;
    logic [IDW-1:0]             rr_ptr;
    logic [NREQ-1:0][WIDTH-1:0] src1_v, src2_v;
    logic [WIDTH-1:0]           lat_a, lat_b, sum;
    logic [IDW-1:0]             lat_id;

    logic [NREQ-1:0] req_rot;
    logic [IDW-1:0]  off, win_id, ptr_nxt;
    logic [IDW:0]    win_sum;
    logic            can_grant;

    assign src1_v = src1_i;
    assign src2_v = src2_i;

    // Rotate requests so bit 0 is rr_ptr; lowest set bit is the winner's offset.
    always_comb begin
        req_rot = NREQ'({req_valid_i, req_valid_i} >> rr_ptr);
        off     = '0;
        for (int i = NREQ-1; i >= 0; i--)
            if (req_rot[i]) off = IDW'(i);
        win_sum = {1'b0, rr_ptr} + {1'b0, off};
        if (win_sum >= NREQ_W) win_sum = win_sum - NREQ_W;
        win_id  = win_sum[IDW-1:0];
    end

    assign ptr_nxt     = (win_id == IDW'(NREQ-1)) ? '0 : win_id + IDW'(1);
    assign can_grant   = !rst_i && (|req_valid_i) &&
                         (state == IDLE || (state == HOLD && res_ready_i));
    assign req_ready_o = can_grant ? (NREQ'(1) << win_id) : '0;
    assign busy_o      = (state != IDLE);

    adder_share_arb_add #(.WIDTH(WIDTH)) u_add (
        .a   (lat_a),
        .b   (lat_b),
        .sum (sum)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            lat_a       <= '0;
            lat_b       <= '0;
            lat_id      <= '0;
            res_valid_o <= 1'b0;
            res_sum_o   <= '0;
            res_id_o    <= '0;
`ifdef ADDER_ARB_OVF_EN
            ovf_o       <= 1'b0;
`endif
        end else begin
            // Grant only happens in IDLE or an accepted HOLD, so latch independently of state.
            if (can_grant) begin
                lat_a  <= src1_v[win_id];
                lat_b  <= src2_v[win_id];
                lat_id <= win_id;
                rr_ptr <= ptr_nxt;
            end
            case (state)
                IDLE: if (can_grant) state <= CALC;
                CALC: begin
                    res_sum_o   <= sum;
                    res_id_o    <= lat_id;
                    res_valid_o <= 1'b1;
`ifdef ADDER_ARB_OVF_EN
                    ovf_o       <= (lat_a[WIDTH-1] == lat_b[WIDTH-1]) &&
                                   (sum[WIDTH-1] != lat_a[WIDTH-1]);
`endif
                    state       <= HOLD;
                end
                HOLD: if (res_ready_i) begin
                    res_valid_o <= 1'b0;
                    state       <= can_grant ? CALC : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_adder_share_arb.sv
// Directed + randomized bench for adder_share_arb against a round-robin/arithmetic model.
// Compile with ADDER_ARB_OVF_EN defined to also check ovf_o.

module tb_adder_share_arb;
    localparam int WIDTH = 32;
    localparam int NREQ  = 4;
    localparam int IDW   = 2;

    logic                  clk_i = 1'b0;
    logic                  rst_i;
    logic [NREQ-1:0]       req_valid_i;
    logic [NREQ-1:0]       req_ready_o;
    logic [NREQ*WIDTH-1:0] src1_i, src2_i;
    logic                  res_valid_o;
    logic                  res_ready_i;
    logic [WIDTH-1:0]      res_sum_o;
    logic [IDW-1:0]        res_id_o;
    logic                  busy_o;
`ifdef ADDER_ARB_OVF_EN
    logic                  ovf_o;
`endif

    adder_share_arb #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .src1_i      (src1_i),
        .src2_i      (src2_i),
        .res_valid_o (res_valid_o),
        .res_ready_i (res_ready_i),
        .res_sum_o   (res_sum_o),
        .res_id_o    (res_id_o),
`ifdef ADDER_ARB_OVF_EN
        .ovf_o       (ovf_o),
`endif
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;

    // Model: per-requester operands, pending set, rr pointer, wait ages.
    logic [WIDTH-1:0] a [NREQ];
    logic [WIDTH-1:0] b [NREQ];
    logic [NREQ-1:0]  pend;
    int               m_ptr;
    int               age [NREQ];
    int               max_wait;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [NREQ-1:0] p, input int ptr);
        for (int i = 0; i < NREQ; i++)
            if (p[(ptr + i) % NREQ]) return (ptr + i) % NREQ;
        return 0;
    endfunction

    task automatic drive();
        for (int k = 0; k < NREQ; k++) begin
            src1_i[k*WIDTH +: WIDTH] = a[k];
            src2_i[k*WIDTH +: WIDTH] = b[k];
        end
    endtask

    task automatic clear_model();
        pend = '0;
        for (int k = 0; k < NREQ; k++) age[k] = 0;
    endtask

    // One transaction from a grant-capable cycle (IDLE or HOLD); leaves DUT in HOLD.
    task automatic txn(input int stall);
        int               w;
        logic [WIDTH-1:0] es;
        logic             eo;
        drive();
        req_valid_i = pend;
        res_ready_i = 1'b1;
        #1;
        w  = pick(pend, m_ptr);
        check("grant", 64'(req_ready_o), 64'(1) << w);
        es = a[w] + b[w];
        eo = (a[w][WIDTH-1] == b[w][WIDTH-1]) && (es[WIDTH-1] != a[w][WIDTH-1]);
        @(posedge clk_i); #1;
        for (int k = 0; k < NREQ; k++)
            if (pend[k] && k != w) age[k]++;
        if (age[w] + 1 > max_wait) max_wait = age[w] + 1;
        age[w]  = 0;
        pend[w] = 1'b0;
        m_ptr   = (w + 1) % NREQ;
        a[w]    = $urandom;
        b[w]    = $urandom;
        drive();
        req_valid_i = pend;
        #1;
        check("calc_rdy", 64'(req_ready_o), 64'(0));
        check("calc_busy", 64'(busy_o), 64'(1));
        check("calc_vld", 64'(res_valid_o), 64'(0));
        @(posedge clk_i); #1;
        check("res_vld", 64'(res_valid_o), 64'(1));
        check("res_sum", 64'(res_sum_o), 64'(es));
        check("res_id", 64'(res_id_o), 64'(w));
`ifdef ADDER_ARB_OVF_EN
        check("res_ovf", 64'(ovf_o), 64'(eo));
`endif
        res_ready_i = 1'b0;
        repeat (stall) begin
            @(posedge clk_i); #1;
            check("hold_vld", 64'(res_valid_o), 64'(1));
            check("hold_sum", 64'(res_sum_o), 64'(es));
            check("hold_id", 64'(res_id_o), 64'(w));
            check("hold_rdy", 64'(req_ready_o), 64'(0));
            check("hold_busy", 64'(busy_o), 64'(1));
        end
    endtask

    task automatic drain();
        clear_model();
        req_valid_i = '0;
        res_ready_i = 1'b1;
        @(posedge clk_i); #1;
        check("drain_vld", 64'(res_valid_o), 64'(0));
        check("drain_busy", 64'(busy_o), 64'(0));
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        m_ptr = 0;
        clear_model();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst_i       = 1'b1;
        req_valid_i = '1;
        res_ready_i = 1'b0;
        src1_i      = '0;
        src2_i      = '0;
        max_wait    = 0;
        m_ptr       = 0;
        for (int k = 0; k < NREQ; k++) begin a[k] = '0; b[k] = '0; end
        clear_model();

        // Reset state, with requests asserted to show grants are suppressed.
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_vld", 64'(res_valid_o), 64'(0));
        check("rst_sum", 64'(res_sum_o), 64'(0));
        check("rst_id", 64'(res_id_o), 64'(0));
        check("rst_busy", 64'(busy_o), 64'(0));
        check("rst_rdy", 64'(req_ready_o), 64'(0));
`ifdef ADDER_ARB_OVF_EN
        check("rst_ovf", 64'(ovf_o), 64'(0));
`endif
        rst_i       = 1'b0;
        req_valid_i = '0;
        @(posedge clk_i); #1;

        // Single request on requester 1: 5 + 7.
        pend = 4'b0010; a[1] = 32'd5; b[1] = 32'd7;
        txn(0);
        check("t1_sum", 64'(res_sum_o), 64'd12);
        check("t1_id", 64'(res_id_o), 64'd1);
        drain();

        // All requesters held: ids rotate 0,1,2,3,0 with one result per 2 cycles.
        do_reset();
        for (int k = 0; k < NREQ; k++) begin a[k] = $urandom; b[k] = $urandom; end
        for (int i = 0; i < 5; i++) begin
            pend = '1;
            txn(0);
            check("t2_seq", 64'(res_id_o), 64'(i % NREQ));
        end
        drain();

        // Wraparound and signed overflow boundaries.
        pend = 4'b0001; a[0] = 32'hFFFF_FFFF; b[0] = 32'h0000_0001;
        txn(0);
        check("t3_wrap", 64'(res_sum_o), 64'h0);
`ifdef ADDER_ARB_OVF_EN
        check("t3_wrap_ovf", 64'(ovf_o), 64'(0));
`endif
        pend = 4'b0001; a[0] = 32'h7FFF_FFFF; b[0] = 32'h0000_0001;
        txn(0);
        check("t3_pos", 64'(res_sum_o), 64'h8000_0000);
`ifdef ADDER_ARB_OVF_EN
        check("t3_pos_ovf", 64'(ovf_o), 64'(1));
`endif
        pend = 4'b0001; a[0] = 32'h8000_0000; b[0] = 32'h8000_0000;
        txn(0);
        check("t3_neg", 64'(res_sum_o), 64'h0);

        // Consumer stalls 5 cycles while every requester is asking.
        pend = '1;
        txn(5);

        // Reset while computing: outputs clear at once, then requester 0 wins.
        req_valid_i = '1;
        res_ready_i = 1'b1;
        @(posedge clk_i); #1;
        check("t5_calc_busy", 64'(busy_o), 64'(1));
        rst_i = 1'b1;
        #1;
        check("t5_vld", 64'(res_valid_o), 64'(0));
        check("t5_sum", 64'(res_sum_o), 64'(0));
        check("t5_busy", 64'(busy_o), 64'(0));
        check("t5_rdy", 64'(req_ready_o), 64'(0));
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        m_ptr = 0;
        clear_model();
        pend = '1;
        txn(0);
        check("t5_id", 64'(res_id_o), 64'(0));

        // Random arrivals, operands and consumer stalls.
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 7) == 0) drain();
            pend = pend | NREQ'($urandom_range(0, (1 << NREQ) - 1));
            if (pend == '0) pend = NREQ'(1) << $urandom_range(0, NREQ - 1);
            txn($urandom_range(0, 3));
        end
        drain();
        check("starvation", 64'(max_wait <= NREQ), 64'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
